// File: rtl/vx_tcu_drl_prod_acc.sv
// Sums groups of up to K signed product terms and emits each group sum with its term count.
// Latency: result valid one cycle after the closing term is accepted; one term per cycle.
// Backpressure: in_ready_o = !out_valid_o | out_ready_i, so a held result freezes the accumulator.
module vx_tcu_drl_prod_acc #(
    parameter int N    = 4,
    parameter int K    = 4,
    parameter int CNTW = $clog2(K + 1),
    parameter int ACCW = 2 * N + $clog2(K) + 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2*N-1:0]  in_prod_i,
    input  logic            in_neg_i,
    input  logic            in_last_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [ACCW-1:0] out_sum_o,
    output logic [CNTW-1:0] out_count_o
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [ACCW-1:0] sum_q, sum_d;
    logic [CNTW-1:0] ocnt_q, ocnt_d;

    logic [ACCW-1:0] term_ext;
    logic [ACCW-1:0] term;
    logic [ACCW-1:0] acc_next;
    logic [CNTW-1:0] cnt_next;
    logic            in_fire;
    logic            out_fire;
    logic            is_final;
    logic            final_fire;

    // Handshakes: readiness depends only on the pending result and downstream ready.
    always_comb begin
        in_ready_o = !out_valid_o || out_ready_i;
        in_fire    = in_valid_i && in_ready_o;
        out_fire   = out_valid_o && out_ready_i;
    end

    // Signed term, running sum and count, and the group-closing condition.
    always_comb begin
        term_ext   = {{(ACCW - 2 * N){1'b0}}, in_prod_i};
        term       = in_neg_i ? (~term_ext + ACCW'(1)) : term_ext;
        acc_next   = acc_q + term;
        cnt_next   = cnt_q + CNTW'(1);
        is_final   = in_last_i || (cnt_next == CNTW'(K));
        final_fire = in_fire && is_final;
    end

    // FSM state register; reset drops any pending result immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a closing term makes a result pending; draining it without a new one clears it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (final_fire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_fire && !final_fire) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // FSM outputs: result valid exactly while a result is pending.
    always_comb begin
        out_valid_o = (state_q == ST_DONE);
        out_sum_o   = sum_q;
        out_count_o = ocnt_q;
    end

    // Datapath next state: accumulate, or hand the finished group to the result registers.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        ocnt_d = ocnt_q;
        if (in_fire) begin
            if (is_final) begin
                sum_d  = acc_next;
                ocnt_d = cnt_next;
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                acc_d  = acc_next;
                cnt_d  = cnt_next;
            end
        end
    end

    // Datapath registers; a partially built group is discarded on reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            ocnt_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            ocnt_q <= ocnt_d;
        end
    end

endmodule

// File: tb/tb_vx_tcu_drl_prod_acc.sv
// Bench for the product accumulator: directed test-plan steps plus random traffic,
// checked every cycle against a group-level model using plain integer sums.
module tb_vx_tcu_drl_prod_acc;

    localparam int N    = 4;
    localparam int K    = 4;
    localparam int CNTW = $clog2(K + 1);
    localparam int ACCW = 2 * N + $clog2(K) + 1;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [2*N-1:0]  in_prod;
    logic            in_neg;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_sum;
    logic [CNTW-1:0] out_count;

    vx_tcu_drl_prod_acc #(.N(N), .K(K)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_prod_i   (in_prod),
        .in_neg_i    (in_neg),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_count_o (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: the group being built (integer sum and term count) and the pending result.
    int g_sum = 0;
    int g_cnt = 0;
    int p_sum = 0;
    int p_cnt = 0;
    bit m_vld = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] as_acc(input int v);
        logic [ACCW-1:0] t;
        t = v[ACCW-1:0];
        return 32'(t);
    endfunction

    // One cycle: drive, check against the model, clock, advance the model. Entered/left at posedge+1.
    task automatic tick(input bit v, input int prod, input bit neg, input bit last, input bit ordy);
        bit mrdy;
        bit acc;
        bit ofire;
        bit closed;
        in_valid  = v;
        in_prod   = v ? prod[2*N-1:0] : 8'($urandom_range(0, 255));
        in_neg    = v ? neg  : 1'($urandom_range(0, 1));
        in_last   = v ? last : 1'($urandom_range(0, 1));
        out_ready = ordy;
        #1;
        mrdy = !m_vld || ordy;
        chk("in_ready", 32'(in_ready), 32'(mrdy));
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        if (m_vld) begin
            chk("out_sum", 32'(out_sum), as_acc(p_sum));
            chk("out_count", 32'(out_count), 32'(p_cnt));
        end
        acc   = v && mrdy;
        ofire = m_vld && ordy;
        @(posedge clk);
        closed = 1'b0;
        if (acc) begin
            g_sum = neg ? g_sum - prod : g_sum + prod;
            g_cnt = g_cnt + 1;
            if (last || g_cnt == K) begin
                p_sum  = g_sum;
                p_cnt  = g_cnt;
                g_sum  = 0;
                g_cnt  = 0;
                closed = 1'b1;
            end
        end
        if (closed) m_vld = 1'b1;
        else if (ofire) m_vld = 1'b0;
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_sum"}, 32'(out_sum), 32'd0);
        chk({tag, "_out_count"}, 32'(out_count), 32'd0);
        g_sum = 0;
        g_cnt = 0;
        m_vld = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_neg    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Four positive 225s: 900.
        for (int i = 0; i < 4; i++) tick(1, 225, 0, 0, 1);
        chk("pos4_sum", 32'(out_sum), 32'h384);
        chk("pos4_count", 32'(out_count), 32'd4);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);

        // Four negative 225s: -900.
        for (int i = 0; i < 4; i++) tick(1, 225, 1, 0, 1);
        chk("neg4_sum", 32'(out_sum), 32'h47C);
        chk("neg4_count", 32'(out_count), 32'd4);
        tick(0, 0, 0, 0, 1);

        // Early close 3 - 5, then single-term group 7.
        tick(1, 3, 0, 0, 1);
        tick(1, 5, 1, 1, 1);
        chk("early_sum", 32'(out_sum), 32'h7FE);
        chk("early_count", 32'(out_count), 32'd2);
        tick(1, 7, 0, 1, 1);
        chk("single_sum", 32'(out_sum), 32'd7);
        chk("single_count", 32'(out_count), 32'd1);
        tick(0, 0, 0, 0, 1);

        // Negative zero term.
        tick(1, 0, 1, 1, 1);
        chk("negzero_sum", 32'(out_sum), 32'd0);
        tick(0, 0, 0, 0, 1);

        // Backpressure: pending 9, three stalled cycles offering 5, then accepted same cycle as release.
        tick(1, 9, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick(1, 5, 0, 1, 0);
        chk("bp_held_sum", 32'(out_sum), 32'd9);
        tick(1, 5, 0, 1, 1);
        chk("bp_new_sum", 32'(out_sum), 32'd5);
        chk("bp_new_count", 32'(out_count), 32'd1);
        tick(0, 0, 0, 0, 1);

        // Throughput: two back-to-back groups 1,2,3,4.
        for (int g = 0; g < 2; g++) begin
            for (int i = 1; i <= 4; i++) tick(1, i, 0, 0, 1);
            chk("tput_sum", 32'(out_sum), 32'd10);
            chk("tput_count", 32'(out_count), 32'd4);
        end
        tick(0, 0, 0, 0, 1);

        // Reset mid-group, then a clean group of four 1s.
        tick(1, 50, 0, 0, 1);
        tick(1, 50, 0, 0, 1);
        async_reset("midrst");
        for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 1);
        chk("postrst_sum", 32'(out_sum), 32'd4);
        chk("postrst_count", 32'(out_count), 32'd4);
        tick(0, 0, 0, 0, 1);

        // Reset while a result is held under backpressure.
        tick(1, 6, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        async_reset("heldrst");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vx_tcu_drl_prod_acc.md
Name: VX_tcu_drl_prod_acc

Overview:
Downstream accumulation stage of the TCU DRL datapath. It consumes the stream of unsigned 2N-bit products from the array multiplier, each with a separate sign bit. It sums groups of up to K signed terms into a two's-complement accumulator, and emits each completed group sum over a valid/ready handshake. One product is accepted per cycle, and back-to-back groups run with no bubbles.

Parameters:
N, 4, multiplier operand width; products are 2N bits.
K, 4, maximum number of terms per group (K >= 2).
CNTW, $clog2(K+1), width of the term-count output.
ACCW, 2N + $clog2(K) + 1, accumulator/result width (signed, cannot overflow).

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  a product term is presented.
in_ready  output  1  the stage can accept a term this cycle.
in_prod  input  2N  unsigned product magnitude.
in_neg  input  1  1 = subtract the term, 0 = add it.
in_last  input  1  the term closes the current group early.
out_valid  output  1  out_sum and out_count hold a completed group.
out_ready  input  1  downstream accepts the result this cycle.
out_sum  output  ACCW  two's-complement group sum.
out_count  output  CNTW  number of terms in the group (1..K).

Behaviour:
- Reset (asynchronous, active-high) sets:
  - out_valid=0, out_sum=0, out_count=0;
  - internal acc=0 and cnt=0; FSM to ACCUM.
  - A partially built group is discarded.
- Handshakes:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational from out_ready only, never from in_valid).
- Term conversion:
  - term = zero-extend(in_prod) to ACCW.
  - If in_neg=1, term is negated in two's complement.
  - in_prod=0 with in_neg=1 yields 0.
- On an input fire:
  - acc_next = acc + term, using ACCW-bit wraparound arithmetic; sizing guarantees no overflow.
  - cnt_next = cnt + 1.
  - The term is final when in_last=1 or cnt_next==K.
- Non-final fire: acc <= acc_next and cnt <= cnt_next; out_* are unchanged.
- Final fire:
  - out_sum <= acc_next, out_count <= cnt_next, out_valid <= 1.
  - acc <= 0 and cnt <= 0.
  - The next accepted term starts a new group.
- Latency: out_valid rises the cycle after the final term is accepted.
- Output hold: while out_valid=1 and out_ready=0:
  - out_sum and out_count are held stable;
  - in_ready=0, so the accumulator is frozen.
- Output fire without a final input fire: out_valid <= 0.
- Simultaneous output fire and final input fire: out_valid stays 1 and out_sum/out_count take the new group. This gives one result per cycle at full throughput.
- Simultaneous output fire and non-final input fire: out_valid <= 0 and the accumulator updates.
- FSM states:
  - ACCUM: cnt==0 or a group is in progress, and no result is pending.
  - DONE: result pending, out_valid=1; the accumulator may also be mid-group.
  - ACCUM->DONE on a final fire.
  - DONE->ACCUM on an output fire that has no coincident final fire.
  - DONE->DONE on a coincident output fire and final fire.
- in_last with cnt==0 produces a single-term group, out_count=1.
- Input fields are ignored when in_valid=0 (X-safe).
- Fully synchronous datapath; no multicycle paths.

Test Plan:
- Reset, then four terms in_prod=225 (N=4, K=4, ACCW=11), in_neg=0, back-to-back, out_ready=1 -> out_valid for exactly 1 cycle, one cycle after the 4th accept; out_sum=900 (0x384), out_count=4.
- Same four terms with in_neg=1 -> out_sum=0x47C (-900), out_count=4.
- Early close: terms 3(+) then 5(-, in_last=1) -> out_sum=0x7FE (-2), out_count=2. A following single term 7(+, in_last=1) -> out_sum=7, out_count=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with a result pending and in_valid=1 -> in_ready=0 and out_sum/out_count stable for those 3 cycles; no term is lost.
  - Then out_ready=1 -> the pending term is accepted the same cycle.
- Throughput: two consecutive groups of K terms 1,2,3,4 with out_ready=1 -> in_ready never drops; results 10 and 10 delivered on consecutive group boundaries.
- Reset mid-operation:
  - Assert reset after 2 of 4 terms -> out_valid=0 immediately, without waiting for a clock edge.
  - After release, 4 terms of 1 -> out_sum=4, out_count=4; the prior partial sum is absent.
